// File: rtl/button_event_scheduler_pkg.sv
// Shared constants for the button event scheduler: event type encoding and default sizing.
package button_pkg;

  typedef enum logic {
    EV_PRESS = 1'b0,
    EV_LONG  = 1'b1
  } ev_type_e;

  localparam int DEF_NUM_BTN     = 4;
  localparam int DEF_HOLD_CYCLES = 50000000;

endpackage

// File: rtl/button_event_scheduler_cell.sv
// Per-button tracker: edge detect, pending PRESS/LONG flags and sticky overrun.
// Hold counter and LONG flag exist only when BUTTON_LONG_PRESS_EN is defined.
module button_event_cell
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr_press,
  input  logic clr_long,
  input  logic clr_overrun,
  output logic pend_press,
  output logic pend_long,
  output logic overrun
);

  logic r_prev;
  logic r_pend_press;
  logic r_overrun;
  logic w_press_set;
  logic w_press_ovr;
  logic w_long_ovr;

  assign w_press_set = btn & ~r_prev;
  assign w_press_ovr = w_press_set & r_pend_press & ~clr_press;

  // prev resets high so a button held through reset release is not seen as a press
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev       <= 1'b1;
      r_pend_press <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_prev       <= btn;
      r_pend_press <= w_press_set | (r_pend_press & ~clr_press);
      r_overrun    <= (r_overrun & ~clr_overrun) | w_press_ovr | w_long_ovr;
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int                CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_VAL = CNT_W'(HOLD_CYCLES);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend_long;
  logic             w_count;
  logic             w_long_set;

  // counting is armed by a real press edge, so a hold across reset never goes LONG
  assign w_count    = btn & (w_press_set | (r_cnt != '0));
  assign w_long_set = w_count & (r_cnt == HOLD_VAL - 1'b1);
  assign w_long_ovr = w_long_set & r_pend_long & ~clr_long;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_pend_long <= 1'b0;
    end else begin
      if (!btn) begin
        r_cnt <= '0;
      end else if (w_count && (r_cnt != HOLD_VAL)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_pend_long <= w_long_set | (r_pend_long & ~clr_long);
    end
  end

  assign pend_long = r_pend_long;
`else
  logic w_unused_long;

  assign w_unused_long = clr_long ^ (HOLD_CYCLES > 1);
  assign w_long_ovr    = 1'b0;
  assign pend_long     = 1'b0;
`endif

  assign pend_press = r_pend_press;
  assign overrun    = r_overrun;

endmodule

// File: rtl/button_event_scheduler.sv
// Button event scheduler: per-button cells feeding a round-robin arbiter with a registered
// valid/ready event output. LONG events only when BUTTON_LONG_PRESS_EN is defined.
module button_event_scheduler
  import button_pkg::*;
#(
  parameter int NUM_BTN     = DEF_NUM_BTN,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn_clean,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [$clog2(NUM_BTN)-1:0] ev_btn,
  output logic                       ev_type,
  output logic [NUM_BTN-1:0]         ev_overrun,
  input  logic                       clr_overrun
);

  localparam int BW = $clog2(NUM_BTN);

  logic [NUM_BTN-1:0] w_pend_press;
  logic [NUM_BTN-1:0] w_pend_long;
  logic [NUM_BTN-1:0] w_overrun;
  logic [BW-1:0]      r_rr_ptr;
  logic [BW-1:0]      r_btn;
  logic               r_valid;
  ev_type_e           r_type;
  logic               w_hs;
  logic               w_found;
  logic [BW-1:0]      w_sel;
  logic [BW-1:0]      w_idx;
  ev_type_e           w_sel_type;

  assign w_hs = r_valid & ev_ready;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
    button_event_cell #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .btn        (btn_clean[i]),
      .clr_press  (w_hs && (r_btn == BW'(i)) && (r_type == EV_PRESS)),
      .clr_long   (w_hs && (r_btn == BW'(i)) && (r_type == EV_LONG)),
      .clr_overrun(clr_overrun),
      .pend_press (w_pend_press[i]),
      .pend_long  (w_pend_long[i]),
      .overrun    (w_overrun[i])
    );
  end

  // first requesting button at or after rr_ptr; PRESS outranks LONG within a button
  always_comb begin
    int j;
    j          = 0;
    w_idx      = '0;
    w_found    = 1'b0;
    w_sel      = '0;
    w_sel_type = EV_PRESS;
    for (int k = 0; k < NUM_BTN; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_BTN) begin
        j = j - NUM_BTN;
      end
      w_idx = BW'(j);
      if (!w_found && (w_pend_press[w_idx] || w_pend_long[w_idx])) begin
        w_found    = 1'b1;
        w_sel      = w_idx;
        w_sel_type = w_pend_press[w_idx] ? EV_PRESS : EV_LONG;
      end
    end
  end

  // after a handshake the slot idles one cycle so the cleared pending bit is settled
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_btn    <= '0;
      r_type   <= EV_PRESS;
      r_rr_ptr <= '0;
    end else if (r_valid) begin
      if (ev_ready) begin
        r_valid  <= 1'b0;
        r_rr_ptr <= (r_btn == BW'(NUM_BTN - 1)) ? '0 : r_btn + 1'b1;
      end
    end else if (w_found) begin
      r_valid <= 1'b1;
      r_btn   <= w_sel;
      r_type  <= w_sel_type;
    end
  end

  assign ev_valid   = r_valid;
  assign ev_btn     = r_btn;
  assign ev_overrun = w_overrun;
`ifdef BUTTON_LONG_PRESS_EN
  assign ev_type    = r_type;
`else
  assign ev_type    = EV_PRESS;
`endif

endmodule
